// File: rtl/maze_trail_writer.sv
// maze_trail_writer: tracks a cursor on an 18x11 grid.
// Button pulses move the cursor one cell. Each cell entered is marked in mazestate.
// Entering a tower cell stops the walk with counter = 255.
// Reaching the five checkpoints in order stops the walk with done = 1.
module maze_trail_writer (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic         restart,
    input  logic [197:0] tower_map,
    output logic [197:0] mazestate,
    output logic [7:0]   counter,
    output logic [7:0]   cursor,
    output logic [2:0]   checkpoint_cnt,
    output logic         done
);

    localparam int COLS = 18;
    localparam int ROWS = 11;

    typedef enum logic [1:0] {PLAY, HIT, DONE} state_t;

    state_t       state, nxt_state;
    // Row and column are kept alongside cursor so edge checks need no divide.
    logic [3:0]   row, nxt_row;
    logic [4:0]   col, nxt_col;
    logic [197:0] nxt_maze;
    logic [7:0]   nxt_counter, nxt_cursor;
    logic [2:0]   nxt_cp;
    logic         nxt_done;

    logic         mv;
    logic [3:0]   t_row;
    logic [4:0]   t_col;
    logic [7:0]   tgt;

    // Cell index of the checkpoint expected next, in visiting order.
    function automatic logic [7:0] cp_cell(input logic [2:0] i);
        case (i)
            3'd0:    cp_cell = 8'd31;
            3'd1:    cp_cell = 8'd37;
            3'd2:    cp_cell = 8'd113;
            3'd3:    cp_cell = 8'd139;
            default: cp_cell = 8'd178;
        endcase
    endfunction

    // Choose the target cell. The highest-priority pulse decides the move.
    // If that move would cross a grid edge, no move is taken.
    always_comb begin
        mv    = 1'b0;
        t_row = row;
        t_col = col;
        if (btn_up) begin
            if (row != 4'd0) begin
                mv    = 1'b1;
                t_row = row - 4'd1;
            end
        end else if (btn_down) begin
            if (row != 4'(ROWS - 1)) begin
                mv    = 1'b1;
                t_row = row + 4'd1;
            end
        end else if (btn_left) begin
            if (col != 5'd0) begin
                mv    = 1'b1;
                t_col = col - 5'd1;
            end
        end else if (btn_right) begin
            if (col != 5'(COLS - 1)) begin
                mv    = 1'b1;
                t_col = col + 5'd1;
            end
        end
        tgt = 8'(t_row) * 8'(COLS) + 8'(t_col);
    end

    // Compute the next state and the next value of every registered output.
    always_comb begin
        nxt_state   = state;
        nxt_row     = row;
        nxt_col     = col;
        nxt_maze    = mazestate;
        nxt_counter = counter;
        nxt_cursor  = cursor;
        nxt_cp      = checkpoint_cnt;
        nxt_done    = done;
        case (state)
            PLAY: begin
                if (mv) begin
                    if (tower_map[tgt]) begin
                        nxt_state   = HIT;
                        nxt_counter = 8'd255;
                    end else begin
                        nxt_row       = t_row;
                        nxt_col       = t_col;
                        nxt_cursor    = tgt;
                        nxt_maze[tgt] = 1'b1;
                        // Cap at 254 so that 255 always means a tower hit.
                        nxt_counter   = (counter < 8'd254) ? counter + 8'd1 : 8'd254;
                        if (tgt == cp_cell(checkpoint_cnt)) begin
                            nxt_cp = checkpoint_cnt + 3'd1;
                            if (checkpoint_cnt == 3'd4) begin
                                nxt_state = DONE;
                                nxt_done  = 1'b1;
                            end
                        end
                    end
                end
            end
            default: ; // HIT and DONE hold every output until reset
        endcase
    end

    // Register state and outputs. Reset and restart take priority over any move.
    always_ff @(posedge CLK) begin
        if (RESET || restart) begin
            state          <= PLAY;
            row            <= '0;
            col            <= '0;
            cursor         <= '0;
            mazestate      <= 198'd1;
            counter        <= '0;
            checkpoint_cnt <= '0;
            done           <= 1'b0;
        end else begin
            state          <= nxt_state;
            row            <= nxt_row;
            col            <= nxt_col;
            cursor         <= nxt_cursor;
            mazestate      <= nxt_maze;
            counter        <= nxt_counter;
            checkpoint_cnt <= nxt_cp;
            done           <= nxt_done;
        end
    end

endmodule

// File: tb/tb_maze_trail_writer.sv
// Testbench for maze_trail_writer.
// Runs directed scenarios first, then randomized single-pulse traffic.
// Every cycle is compared against a grid-walk model kept in the bench.
module tb_maze_trail_writer;

    logic         CLK = 1'b0;
    logic         RESET, btn_up, btn_down, btn_left, btn_right, restart;
    logic [197:0] tower_map;
    logic [197:0] mazestate;
    logic [7:0]   counter, cursor;
    logic [2:0]   checkpoint_cnt;
    logic         done;

    maze_trail_writer dut (
        .CLK(CLK), .RESET(RESET), .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right), .restart(restart),
        .tower_map(tower_map), .mazestate(mazestate), .counter(counter),
        .cursor(cursor), .checkpoint_cnt(checkpoint_cnt), .done(done)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Model: position, visited set, move count, checkpoints, and status.
    // Status is 0 = playing, 1 = tower hit, 2 = finished.
    int           cps[5] = '{31, 37, 113, 139, 178};
    int           m_row, m_col, m_cnt, m_cp, m_st;
    logic [197:0] m_vis;

    task automatic chk(input string tag, input logic [197:0] obs, input logic [197:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit u, input bit d, input bit l, input bit r, input bit rs);
        int  nr, nc, t;
        bit  mv;
        nr = m_row; nc = m_col; mv = 0;
        if (rs) begin
            m_row = 0; m_col = 0; m_cnt = 0; m_cp = 0; m_st = 0; m_vis = 198'd1;
        end else if (m_st == 0) begin
            if (u)      begin if (m_row > 0)  begin nr = m_row - 1; mv = 1; end end
            else if (d) begin if (m_row < 10) begin nr = m_row + 1; mv = 1; end end
            else if (l) begin if (m_col > 0)  begin nc = m_col - 1; mv = 1; end end
            else if (r) begin if (m_col < 17) begin nc = m_col + 1; mv = 1; end end
            if (mv) begin
                t = nc + 18 * nr;
                if (tower_map[t]) begin
                    m_st = 1; m_cnt = 255;
                end else begin
                    m_row = nr; m_col = nc; m_vis[t] = 1'b1;
                    if (m_cnt < 254) m_cnt++;
                    if (m_cp < 5 && t == cps[m_cp]) begin
                        m_cp++;
                        if (m_cp == 5) m_st = 2;
                    end
                end
            end
        end
    endtask

    // One clock cycle: drive inputs, advance the model, check every output.
    task automatic cyc(input bit u, input bit d, input bit l, input bit r,
                       input bit rst = 0, input bit rsr = 0);
        @(negedge CLK);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
        RESET = rst; restart = rsr;
        model_step(u, d, l, r, rst | rsr);
        @(posedge CLK);
        #1;
        chk("cursor", 198'(cursor), 198'(m_col + 18 * m_row));
        chk("mazestate", mazestate, m_vis);
        chk("counter", 198'(counter), 198'(m_cnt));
        chk("checkpoint_cnt", 198'(checkpoint_cnt), 198'(m_cp));
        chk("done", 198'(done), 198'(m_st == 2));
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; RESET = 0; restart = 0;
    endtask

    // Walk rows first, then columns.
    task automatic go_to(input int row, input int col);
        while (m_row < row) cyc(0, 1, 0, 0);
        while (m_row > row) cyc(1, 0, 0, 0);
        while (m_col < col) cyc(0, 0, 0, 1);
        while (m_col > col) cyc(0, 0, 1, 0);
    endtask

    initial begin
        int sel;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; restart = 0; RESET = 0;
        m_row = 0; m_col = 0; m_cnt = 0; m_cp = 0; m_st = 0; m_vis = 198'd1;
        // Reset with a tower on cell 0; that tower must be ignored.
        tower_map = 198'd1;
        cyc(0, 0, 0, 0, 1);
        chk("reset_cursor", 198'(cursor), 198'd0);
        chk("reset_maze", mazestate, 198'd1);
        tower_map = '0;

        // Three right moves.
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
        chk("right3_cursor", 198'(cursor), 198'd3);
        chk("right3_maze", mazestate, 198'hF);
        chk("right3_counter", 198'(counter), 198'd3);
        cyc(0, 0, 0, 0);
        chk("idle_hold_counter", 198'(counter), 198'd3);

        // Edge moves are ignored, and a right move does not wrap to the next row.
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0); cyc(0, 0, 1, 0);
        chk("edge_cursor", 198'(cursor), 198'd0);
        chk("edge_counter", 198'(counter), 198'd0);
        go_to(0, 17);
        cyc(0, 0, 0, 1);
        chk("nowrap_cursor", 198'(cursor), 198'd17);
        chk("nowrap_counter", 198'(counter), 198'd17);

        // Tower hit: later moves are ignored until restart.
        cyc(0, 0, 0, 0, 1);
        tower_map[1] = 1'b1;
        cyc(0, 0, 0, 1);
        chk("hit_counter", 198'(counter), 198'd255);
        chk("hit_cursor", 198'(cursor), 198'd0);
        chk("hit_maze", mazestate, 198'd1);
        cyc(0, 1, 0, 0); cyc(0, 0, 0, 1);
        chk("hit_hold_counter", 198'(counter), 198'd255);
        chk("hit_hold_cursor", 198'(cursor), 198'd0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("restart_counter", 198'(counter), 198'd0);
        tower_map = '0;

        // Simultaneous pulses at cell 18: only the up move is taken.
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 1);
        chk("prio_cursor", 198'(cursor), 198'd0);
        chk("prio_counter", 198'(counter), 198'd2);

        // Entering 37 before 31 does not count; entering 31 afterwards does.
        cyc(0, 0, 0, 0, 1);
        go_to(2, 1);
        chk("ooo_cp_at37", 198'(checkpoint_cnt), 198'd0);
        go_to(1, 13);
        chk("ooo_cp_at31", 198'(checkpoint_cnt), 198'd1);

        // Full ordered checkpoint path, then moves are ignored.
        cyc(0, 0, 0, 0, 0, 1);
        go_to(1, 13); go_to(2, 1); go_to(6, 5); go_to(7, 13); go_to(9, 16);
        chk("path_cp", 198'(checkpoint_cnt), 198'd5);
        chk("path_done", 198'(done), 198'd1);
        cyc(1, 0, 0, 0); cyc(0, 0, 1, 0);
        chk("done_hold_cursor", 198'(cursor), 198'd178);

        // Counter saturates at 254.
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) cyc(0, 0, 0, 1);
            else            cyc(0, 0, 1, 0);
        end
        chk("sat_counter", 198'(counter), 198'd254);
        // Reset together with a move: the move is dropped.
        cyc(0, 0, 0, 1, 1);
        chk("rst_move_cursor", 198'(cursor), 198'd0);
        chk("rst_move_counter", 198'(counter), 198'd0);

        // Random single-pulse traffic with sparse, changing tower maps.
        for (int i = 0; i < 3000; i++) begin
            if (i % 8 == 0) begin
                tower_map = '0;
                for (int k = 0; k < 3; k++) tower_map[$urandom_range(197, 0)] = 1'b1;
            end
            sel = $urandom_range(99, 0);
            if (sel < 1)       cyc(0, 0, 0, $urandom_range(1, 0), 1, 0);
            else if (sel < 3)  cyc($urandom_range(1, 0), 0, 0, 0, 0, 1);
            else if (sel < 25) cyc(1, 0, 0, 0);
            else if (sel < 50) cyc(0, 1, 0, 0);
            else if (sel < 72) cyc(0, 0, 1, 0);
            else if (sel < 97) cyc(0, 0, 0, 1);
            else               cyc(0, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maze_trail_writer.md
MAZE_TRAIL_WRITER -- requirements
Module: maze_trail_writer

Interface
REQ-001 The block SHALL have the following ports, one clock domain, all outputs registered:
- CLK  in  1  system clock, all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- btn_up  in  1  one-cycle move pulse, row-1
- btn_down  in  1  one-cycle move pulse, row+1
- btn_left  in  1  one-cycle move pulse, col-1
- btn_right  in  1  one-cycle move pulse, col+1
- restart  in  1  one-cycle pulse, same effect as RESET
- tower_map  in  198  bit i = 1 marks cell i as forbidden
- mazestate  out  198  bit i = 1 marks cell i as visited; feeds the maze renderer
- counter  out  8  move count; 255 = tower hit
- cursor  out  8  current cell index, 0..197
- checkpoint_cnt  out  3  number of checkpoints reached in order, 0..5
- done  out  1  high once all 5 checkpoints are reached
REQ-002 The grid SHALL be 18 columns x 11 rows, cell index = col + 18*row.

Function
REQ-003 The FSM SHALL have three states: PLAY, HIT, DONE.
REQ-004 In PLAY, a move pulse SHALL be evaluated in its cycle, with all resulting output updates visible one cycle later.
REQ-005 Simultaneous pulses SHALL resolve by priority up > down > left > right; only one move is taken per cycle.
REQ-006 A move past a grid edge SHALL be ignored with no output change. Edges: row 0 for up, row 10 for down, col 0 for left, col 17 for right. Left/right SHALL NOT wrap to the adjacent row.
REQ-007 When tower_map[target] = 1, the block SHALL go to HIT: counter <= 255; cursor and mazestate unchanged.
REQ-008 Otherwise the block SHALL take the move:
- cursor <= target
- mazestate[target] <= 1
- counter <= counter+1, saturating at 254
REQ-009 Revisiting an already-visited cell SHALL count as a legal move. Its mazestate bit stays 1 and counter still increments.
REQ-010 The checkpoint sequence SHALL be cells 31, 37, 113, 139, 178, in that order.
REQ-011 Entering the next expected checkpoint on a legal move SHALL increment checkpoint_cnt in the same update.
REQ-012 Entering a checkpoint out of order SHALL be a normal move with no checkpoint_cnt change.
REQ-013 When checkpoint_cnt becomes 5, the block SHALL enter DONE with done = 1 in the same update as the final move.
REQ-014 In HIT and DONE, all move pulses SHALL be ignored and all outputs held until RESET or restart.
REQ-015 tower_map SHALL be sampled only when a move is evaluated. A tower bit set on the cursor cell or on a visited cell has no effect until that cell is entered again.
REQ-016 Every output SHALL hold its value in any cycle with no move and no reset.

Reset
REQ-017 When RESET = 1 or restart = 1 at a rising edge, the block SHALL set:
- state <= PLAY
- cursor <= 0
- mazestate <= only bit 0 set
- counter <= 0
- checkpoint_cnt <= 0
- done <= 0
REQ-018 RESET/restart SHALL override any move pulse in the same cycle.
REQ-019 Reset SHALL take effect in any state, including mid-path and in HIT or DONE.
REQ-020 tower_map[0] SHALL be ignored at reset.

Verification
REQ-021 The bench SHALL cover at least these directed scenarios:
- Reset, then btn_right x3 with tower_map = 0 -> cursor = 3, mazestate bits 0..3 = 1, counter = 3, state PLAY.
- From reset: btn_up, then btn_left -> no change; cursor = 0, counter = 0. Then btn_right to cell 17 followed by btn_right -> cursor stays 17, no wrap to cell 18.
- tower_map[1] = 1, pulse btn_right -> next cycle counter = 255, cursor = 0, mazestate = 1. Further moves ignored; restart -> counter = 0.
- Same-cycle btn_up + btn_down + btn_right at cell 18 -> cursor = 0; only the up move is taken.
- Path through 37 before 31 -> checkpoint_cnt stays 0 at 37, becomes 1 at 31. Full ordered path 31, 37, 113, 139, 178 -> checkpoint_cnt = 5, done = 1; later moves ignored.
- More than 254 legal moves -> counter saturates at 254, never reaches 255 without a tower hit. RESET asserted together with a move -> reset values, move dropped.
